// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and the coordinate type shared by the scan
// generator and every overlay block that decodes its coordinates.
package vga_timing_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int PIX_DIV = 2;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: [START, END)
    localparam int HSYNC_START = H_VIS + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC;
    localparam int VSYNC_START = V_VIS + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: tick is the combinational terminal count (divider at
// PIX_DIV-1), i.e. "the counters advance on this edge".
module pix_tick_gen #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan timing generator: pixel coordinates, active-low syncs, blanking.
// Optional completed-frame counter enabled by defining VGA_SCAN_FRAME_CNT_EN.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS   = vga_timing_pkg::H_VIS,
    parameter int H_FP    = vga_timing_pkg::H_FP,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BP    = vga_timing_pkg::H_BP,
    parameter int V_VIS   = vga_timing_pkg::V_VIS,
    parameter int V_FP    = vga_timing_pkg::V_FP,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BP    = vga_timing_pkg::V_BP,
    parameter int PIX_DIV = vga_timing_pkg::PIX_DIV
) (
    input  logic       clk,
    input  logic       rst,
    output coord_t     xCount,
    output coord_t     yCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_VIS + H_FP;
    localparam int HS_END      = HS_START + H_SYNC;
    localparam int VS_START    = V_VIS + V_FP;
    localparam int VS_END      = VS_START + V_SYNC;

    generate
        if (LINE_LEN > 1024 || FRAME_LINES > 1024) begin : g_bad_total
            $error("vga_scan_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
        end
        if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
            $error("vga_scan_gen: PIX_DIV must be in 1..16");
        end
    endgenerate

    logic   adv;
    logic   x_last;
    logic   y_last;
    coord_t x_nxt;
    coord_t y_nxt;

    pix_tick_gen #(.PIX_DIV(PIX_DIV)) u_pix_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (adv)
    );

    assign x_last = (xCount == coord_t'(LINE_LEN - 1));
    assign y_last = (yCount == coord_t'(FRAME_LINES - 1));

    always_comb begin
        x_nxt = xCount;
        y_nxt = yCount;
        if (adv) begin
            if (x_last) begin
                x_nxt = '0;
                y_nxt = y_last ? '0 : yCount + 1'b1;
            end else begin
                x_nxt = xCount + 1'b1;
            end
        end
    end

    // Syncs and blanking decode the next-state coordinates so they line up
    // with the coordinates presented on the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xCount      <= '0;
            yCount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            xCount      <= x_nxt;
            yCount      <= y_nxt;
            hsync       <= !(x_nxt >= coord_t'(HS_START) && x_nxt < coord_t'(HS_END));
            vsync       <= !(y_nxt >= coord_t'(VS_START) && y_nxt < coord_t'(VS_END));
            video_on    <= (x_nxt < coord_t'(H_VIS)) && (y_nxt < coord_t'(V_VIS));
            pix_tick    <= adv;
            frame_start <= adv && x_last && y_last;
        end
    end

`ifdef VGA_SCAN_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_count <= 8'd0;
        end else if (adv && x_last && y_last) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: two instances with shrunken timing
// (PIX_DIV=2 and PIX_DIV=1) checked against an arithmetic raster model.
module tb_vga_scan_gen;

    localparam int A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VV = 5, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam int A_PD = 2;
    localparam int B_HV = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_PD = 1;
    localparam int B_FRAME_CLK = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB) * B_PD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] xa, ya, xb, yb;
    logic       hsa, vsa, vona, tka, fsa;
    logic       hsb, vsb, vonb, tkb, fsb;
    logic [7:0] fca, fcb;

    vga_scan_gen #(
        .H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .PIX_DIV(A_PD)
    ) dut_a (
        .clk(clk), .rst(rst), .xCount(xa), .yCount(ya), .hsync(hsa), .vsync(vsa),
        .video_on(vona), .pix_tick(tka), .frame_start(fsa), .frame_count(fca)
    );

    vga_scan_gen #(
        .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .PIX_DIV(B_PD)
    ) dut_b (
        .clk(clk), .rst(rst), .xCount(xb), .yCount(yb), .hsync(hsb), .vsync(vsb),
        .video_on(vonb), .pix_tick(tkb), .frame_start(fsb), .frame_count(fcb)
    );

    typedef struct {
        int x, y, hs, vs, von, tick, fs, fc;
    } exp_t;

    // n = clock edges since reset release; everything follows from the
    // number of pixel ticks that have elapsed.
    function automatic exp_t model(int n, int pd, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        exp_t e;
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int p  = n / pd;
        e.x    = p % ht;
        e.y    = (p / ht) % vt;
        e.hs   = (e.x >= hv + hf && e.x < hv + hf + hs) ? 0 : 1;
        e.vs   = (e.y >= vv + vf && e.y < vv + vf + vs) ? 0 : 1;
        e.von  = (e.x < hv && e.y < vv) ? 1 : 0;
        e.tick = (n > 0 && n % pd == 0) ? 1 : 0;
        e.fs   = (e.tick == 1 && p % (ht * vt) == 0) ? 1 : 0;
`ifdef VGA_SCAN_FRAME_CNT_EN
        e.fc   = (p / (ht * vt)) % 256;
`else
        e.fc   = 0;
`endif
        return e;
    endfunction

    exp_t qa[$];
    exp_t qb[$];
    int   n    = 0;
    int   vec  = 0;
    int   miss = 0;

    task automatic chk(input string tag, input int got, input int want);
        vec++;
        if (got != want) begin
            miss++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        if (!r) n = 0;
        else    n++;
        qa.push_back(model(n, A_PD, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB));
        qb.push_back(model(n, B_PD, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB));
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("A.xCount", int'(xa), e.x);
            chk("A.yCount", int'(ya), e.y);
            chk("A.hsync", int'(hsa), e.hs);
            chk("A.vsync", int'(vsa), e.vs);
            chk("A.video_on", int'(vona), e.von);
            chk("A.pix_tick", int'(tka), e.tick);
            chk("A.frame_start", int'(fsa), e.fs);
            chk("A.frame_count", int'(fca), e.fc);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("B.xCount", int'(xb), e.x);
            chk("B.yCount", int'(yb), e.y);
            chk("B.hsync", int'(hsb), e.hs);
            chk("B.vsync", int'(vsb), e.vs);
            chk("B.video_on", int'(vonb), e.von);
            chk("B.pix_tick", int'(tkb), e.tick);
            chk("B.frame_start", int'(fsb), e.fs);
            chk("B.frame_count", int'(fcb), e.fc);
        end
    end

    initial begin
        exp_t m;
        bit   found;

        repeat (5) step(1'b0);
        repeat (600) step(1'b1);

        // Reset while instance A is inside its horizontal sync pulse.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            m = model(n, A_PD, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB);
            if (m.hs == 0) found = 1'b1;
            else           step(1'b1);
        end
        if (found) begin
            chk("A.hsync_before_midsync_reset", int'(hsa), 0);
            step(1'b0);
            step(1'b1);
        end else begin
            chk("A.hsync_window_reached", 0, 1);
        end

        repeat (6) begin
            repeat ($urandom_range(20, 300)) step(1'b1);
            repeat ($urandom_range(1, 3)) step(1'b0);
        end

        // Long run: 257 frames of instance B covers the 8-bit counter wrap.
        repeat (257 * B_FRAME_CLK + 60) step(1'b1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
